// File: rtl/data_mem_responder.sv
`timescale 1ns/1ps
// Data-memory responder for the core's MEM stage: one request at a time,
// fixed access latency, registered response with misalign/range error.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 =
        (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        acc;
    logic        commit;

    logic        cap_write;
    logic [63:0] cap_addr;
    logic [63:0] cap_wdata;

    logic        eff_write;
    logic [63:0] eff_addr;
    logic [63:0] eff_wdata;
    logic        eff_err;
    logic [AW-1:0] eff_idx;

    logic [63:0] mem [DEPTH];

    // Next state, latency counter and the accept/commit strobes.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc       = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    acc = 1'b1;
                    if (LATENCY == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        commit = (state != RESP) && (state_nxt == RESP);
    end

    // With zero latency the access commits on the accept edge itself,
    // so the live request is used instead of the not-yet-captured copy.
    always_comb begin
        eff_write = cap_write;
        eff_addr  = cap_addr;
        eff_wdata = cap_wdata;
        if (state == IDLE) begin
            eff_write = req_write;
            eff_addr  = req_addr;
            eff_wdata = req_wdata;
        end
        eff_err = (eff_addr[2:0] != 3'b0) ||
                  (eff_addr[63:3] >= 61'(DEPTH));
        eff_idx = eff_addr[AW+2:3];
    end

    // Control state, captured request and registered response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            cap_write  <= 1'b0;
            cap_addr   <= 64'd0;
            cap_wdata  <= 64'd0;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (acc) begin
                cap_write <= req_write;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end
            if (commit) begin
                resp_err <= eff_err;
                if (eff_err || eff_write) begin
                    resp_rdata <= 64'd0;
                end else begin
                    resp_rdata <= mem[eff_idx];
                end
            end
        end
    end

    // Storage is deliberately not reset; stores land on the RESP-entry edge.
    always_ff @(posedge clk) begin
        if (commit && eff_write && !eff_err) begin
            mem[eff_idx] <= eff_wdata;
        end
    end

    assign req_ready  = (state == IDLE);
    assign busy       = ~req_ready;
    assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
// Bench for data_mem_responder: transaction-level model checked every
// cycle, directed corner cases, random traffic, and a zero-latency build.
module tb_data_mem_responder;

    localparam int DEPTH = 16;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err, busy;
    logic [63:0] resp_rdata;

    logic        z_req_valid, z_req_ready, z_req_write;
    logic [63:0] z_req_addr, z_req_wdata;
    logic        z_resp_valid, z_resp_ready, z_resp_err, z_busy;
    logic [63:0] z_resp_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy)
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_write(z_req_write), .req_addr(z_req_addr),
        .req_wdata(z_req_wdata), .resp_valid(z_resp_valid),
        .resp_ready(z_resp_ready), .resp_rdata(z_resp_rdata),
        .resp_err(z_resp_err), .busy(z_busy)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Transaction-level reference: pending request with its accept cycle.
    int          cyc = 0;
    int          acc_cyc = 0;
    bit          m_wait = 0;
    bit          m_resp = 0;
    bit          m_known = 0;
    logic        mw;
    logic [63:0] ma, md;
    logic [63:0] m_rdata = 0;
    bit          m_err = 0;
    logic [63:0] mem_m [DEPTH];
    bit          known [DEPTH];

    task automatic m_commit();
        logic [63:0] w;
        int idx;
        w = ma >> 3;
        m_err = (ma[2:0] != 3'd0) || (w >= 64'(DEPTH));
        m_rdata = 64'd0;
        m_known = 1;
        if (!m_err) begin
            idx = int'(w);
            if (mw) begin
                mem_m[idx] = md;
                known[idx] = 1;
            end else begin
                m_rdata = mem_m[idx];
                m_known = known[idx];
            end
        end
        m_resp = 1;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_wait = 0;
            m_resp = 0;
        end else begin
            cyc++;
            if (m_resp) begin
                if (resp_ready) m_resp = 0;
            end else if (m_wait) begin
                if (cyc - acc_cyc == LAT) begin
                    m_wait = 0;
                    m_commit();
                end
            end else if (req_valid) begin
                mw = req_write;
                ma = req_addr;
                md = req_wdata;
                acc_cyc = cyc;
                if (LAT == 0) m_commit();
                else m_wait = 1;
            end
        end
    end

    always @(negedge clk) begin
        bit b;
        b = m_wait || m_resp;
        chk("ctl{ready,busy,valid}",
            64'({req_ready, busy, resp_valid}),
            64'({!b, b, m_resp}));
        if (m_resp) begin
            chk("model_err", 64'(resp_err), 64'(m_err));
            if (m_known) chk("model_rdata", resp_rdata, m_rdata);
        end
    end

    function automatic logic [63:0] rand_addr();
        int r;
        logic [63:0] a;
        r = $urandom_range(0, 9);
        a = 64'($urandom_range(0, DEPTH - 1)) << 3;
        if (r == 0) a = a | 64'($urandom_range(1, 7));
        else if (r == 1) a = {$urandom, $urandom} & ~64'd7;
        else if (r == 2) a = 64'(DEPTH) << 3;
        return a;
    endfunction

    task automatic wait_resp(output int lat);
        lat = 0;
        @(negedge clk);
        while (!resp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) begin
            tests++;
            fails++;
            $display("FAIL resp_timeout: resp_valid=0 required 1");
        end
    endtask

    task automatic txn(input logic w, input logic [63:0] a,
                       input logic [63:0] d, input int hold,
                       output logic [63:0] rd, output logic er,
                       output int lat);
        int n;
        @(posedge clk); #1;
        req_valid = 1; req_write = w;
        req_addr = a; req_wdata = d;
        resp_ready = 0;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: req_ready=0 required 1");
        end
        @(posedge clk); #1;
        req_valid = 0; req_write = ~w;
        req_addr = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        wait_resp(lat);
        rd = resp_rdata;
        er = resp_err;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_rdata", resp_rdata, rd);
            chk("hold_err", 64'(resp_err), 64'(er));
            chk("hold_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1 resp_ready = 1;
        @(posedge clk); #1 resp_ready = 0;
    endtask

    logic [63:0] pre [DEPTH];

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;
        reset_n = 0;
        req_valid = 0; req_write = 0;
        req_addr = 0; req_wdata = 0; resp_ready = 0;
        z_req_valid = 0; z_req_write = 0;
        z_req_addr = 0; z_req_wdata = 0; z_resp_ready = 0;
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_err", 64'(resp_err), 64'd0);
        @(posedge clk); #1 reset_n = 1;

        for (int i = 0; i < DEPTH; i++) begin
            pre[i] = {$urandom, $urandom};
            txn(1, 64'(i) << 3, pre[i], 0, rd, er, lat);
            chk("prefill_err", 64'(er), 64'd0);
        end

        txn(1, 64'h10, 64'hDEADBEEF_01234567, 0, rd, er, lat);
        chk("st_lat", 64'(lat), 64'd2);
        chk("st_err", 64'(er), 64'd0);
        chk("st_rdata", rd, 64'd0);
        txn(0, 64'h10, 64'h0, 0, rd, er, lat);
        chk("ld_lat", 64'(lat), 64'd2);
        chk("ld_rdata", rd, 64'hDEADBEEF_01234567);
        txn(0, 64'h0C, 64'h0, 0, rd, er, lat);
        chk("mis_err", 64'(er), 64'd1);
        chk("mis_rdata", rd, 64'd0);
        txn(1, 64'(8 * DEPTH), 64'h1111, 0, rd, er, lat);
        chk("oor_err", 64'(er), 64'd1);
        txn(0, 64'(8 * (DEPTH - 1)), 64'h0, 0, rd, er, lat);
        chk("last_word", rd, pre[DEPTH-1]);
        txn(0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 0, rd, er, lat);
        chk("huge_err", 64'(er), 64'd1);

        @(posedge clk); #1;
        req_valid = 1; req_write = 0;
        req_addr = 64'h10; resp_ready = 0;
        @(negedge clk);
        @(posedge clk); #1;
        req_addr = 64'h18;
        wait_resp(lat);
        rd = resp_rdata;
        chk("bp_rdata", rd, 64'hDEADBEEF_01234567);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 64'(resp_valid), 64'd1);
            chk("bp_rdata_hold", resp_rdata, rd);
            chk("bp_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1 resp_ready = 1;
        @(posedge clk); #1 resp_ready = 0;
        @(negedge clk);
        chk("bp_idle_ready", 64'(req_ready), 64'd1);
        chk("bp_idle_valid", 64'(resp_valid), 64'd0);
        @(posedge clk); #1 req_valid = 0;
        @(negedge clk);
        chk("bp_next_busy", 64'(busy), 64'd1);
        wait_resp(lat);
        chk("bp_next_rdata", resp_rdata, pre[3]);
        @(posedge clk); #1 resp_ready = 1;
        @(posedge clk); #1 resp_ready = 0;

        txn(1, 64'h20, 64'd3, 0, rd, er, lat);
        txn(0, 64'h0D, 64'd0, 0, rd, er, lat);
        chk("pre_rst_err", 64'(er), 64'd1);
        @(posedge clk); #1;
        req_valid = 1; req_write = 1;
        req_addr = 64'h20; req_wdata = 64'd7;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 0;
        #2 reset_n = 0;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_valid", 64'(resp_valid), 64'd0);
        chk("mid_rst_rdata", resp_rdata, 64'd0);
        chk("mid_rst_err", 64'(resp_err), 64'd0);
        @(negedge clk) reset_n = 1;
        txn(0, 64'h20, 64'd0, 0, rd, er, lat);
        chk("rst_abort_rdata", rd, 64'd3);

        txn(1, 64'h40, 64'h0123_4567_89AB_CDEF, 2, rd, er, lat);
        txn(0, 64'h40, 64'd0, 0, rd, er, lat);
        chk("capture_rdata", rd, 64'h0123_4567_89AB_CDEF);

        @(posedge clk); #1;
        z_req_valid = 1; z_req_write = 1;
        z_req_addr = 64'h0; z_req_wdata = 64'd5;
        @(posedge clk); #1;
        z_req_valid = 0; z_req_addr = 64'h8;
        @(negedge clk);
        chk("z_st_valid", 64'(z_resp_valid), 64'd1);
        chk("z_st_err", 64'(z_resp_err), 64'd0);
        chk("z_st_rdata", z_resp_rdata, 64'd0);
        chk("z_st_ready", 64'(z_req_ready), 64'd0);
        @(posedge clk); #1 z_resp_ready = 1;
        @(posedge clk); #1 z_resp_ready = 0;
        @(negedge clk);
        chk("z_idle_ready", 64'(z_req_ready), 64'd1);
        z_req_valid = 1; z_req_write = 0; z_req_addr = 64'h0;
        @(posedge clk); #1 z_req_valid = 0;
        @(negedge clk);
        chk("z_ld_valid", 64'(z_resp_valid), 64'd1);
        chk("z_ld_rdata", z_resp_rdata, 64'd5);
        @(posedge clk); #1 z_resp_ready = 1;
        @(posedge clk); #1 z_resp_ready = 0;

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            req_valid  = 1'($urandom_range(0, 1));
            req_write  = 1'($urandom_range(0, 1));
            req_addr   = rand_addr();
            req_wdata  = {$urandom, $urandom};
            resp_ready = ($urandom_range(0, 3) != 0);
            if (c == 1500) begin
                #2 reset_n = 0;
                @(negedge clk) reset_n = 1;
            end
        end
        @(posedge clk); #1;
        req_valid = 0; resp_ready = 1;
        repeat (LAT + 4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the CPU's data-memory port: accepts one load or store request at a time from the pipeline's MEM stage over a valid/ready handshake, models a configurable access latency, and returns read data plus an error flag over a second valid/ready handshake. It replaces the zero-latency data memory behind the pipelined core. While it is busy, the core stalls its EX/MEM and MEM/WB pipeline registers.

## Interface
- `DEPTH`, 256: number of 64-bit words of storage; `DEPTH` is a power of two, ≥2.
- `LATENCY`, 2: wait cycles between request acceptance and response; legal range 0..15.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  one clock; reset is asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  64  byte address.
- `req_wdata`  in  64  store data.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  initiator accepts the response.
- `resp_rdata`  out  64  load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned or out-of-range access.
- `busy`  out  1  equals `~req_ready`; drives the pipeline-register stall.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - WAIT: counting latency.
  - RESP: `resp_valid`=1.
- IDLE, `req_valid`=1: request accepted at the edge. `req_write`, `req_addr` and `req_wdata` are captured into internal registers; later input changes are ignored.
  - `LATENCY`=0: go directly to RESP.
  - Otherwise: load the counter with `LATENCY`-1 and go to WAIT.
- WAIT: if counter==0, go to RESP at this edge; otherwise decrement.
- Access commits at the edge that enters RESP:
  - Error check: error if captured `addr[2:0]`≠0 or `addr[63:3]`≥`DEPTH`.
  - Error: no write, `resp_rdata`=0, `resp_err`=1.
  - Store: `mem[addr[63:3]]` ← wdata, `resp_rdata`=0, `resp_err`=0.
  - Load: `resp_rdata` ← `mem[addr[63:3]]`, `resp_err`=0.
- RESP: outputs are held stable until `resp_valid`&`resp_ready`, then go to IDLE at that edge.
- A new request cannot be accepted in the same cycle as the response handshake. There is one mandatory IDLE cycle between transactions.
- Storage is not cleared by reset; contents are undefined until written.
- Address arithmetic uses unsigned 64-bit compares; there is no wrap-around of word index, and out-of-range accesses are errors, not aliases.

## Timing
- Reset (async assert, sync-safe deassert) forces:
  - state IDLE, counter 0
  - `req_ready`=1, `busy`=0
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0
  - captured request registers 0
- Reset mid-transaction aborts it:
  - Asserted before the RESP-entry edge: the store is not committed.
  - Asserted after that edge: the store stays committed.
- Accept at edge k; `resp_valid` goes high after edge k+`LATENCY`; response-to-next-accept minimum is 2 edges.
- Throughput with `resp_ready` tied high: one transaction per `LATENCY`+2 cycles.
- `req_ready`, `busy`, `resp_valid`, `resp_rdata` and `resp_err` are all registered or decoded from state only. There is no combinational path from any input to any output.
- `req_valid` while not in IDLE has no effect. The request is not queued, and the initiator holds it until `req_ready`.
- `resp_valid` never drops without a handshake or reset.

## Test plan
- `LATENCY`=2:
  - Store 0xDEADBEEF_01234567 to addr 0x10 at edge k: `busy`=1 after k, `resp_valid`=1 after k+2, `resp_err`=0, `resp_rdata`=0.
  - Load addr 0x10 afterwards: `resp_rdata`=0xDEADBEEF_01234567 after k'+2.
- Error cases:
  - Load addr 0x0C (misaligned): `resp_err`=1, `resp_rdata`=0.
  - Store to addr 8·`DEPTH`: `resp_err`=1, and a subsequent load of word `DEPTH`-1 is unchanged.
- Backpressure: hold `resp_ready`=0 for 5 cycles in RESP. `resp_valid`, `resp_rdata` and `resp_err` must stay stable and `req_ready` stays 0. Then pulse `resp_ready`: IDLE next cycle, and a new accept no earlier than one cycle later.
- `LATENCY`=0 build: store 5 to addr 0, then load addr 0. Each `resp_valid` appears right after its accept edge, and the load returns 5.
- Reset mid-op: store 7 to addr 0x20 (word previously 3), assert `reset_n`=0 during WAIT. All outputs take their reset values immediately; a later load of 0x20 returns 3.
- Request changes: change `req_addr` and `req_wdata` during WAIT. The response reflects only the captured values.
